// File: rtl/ifetch_ctrl.sv
// Fetch sequencer/arbiter for the instruction queue: issues I-cache line requests only
// when queue space is guaranteed, steers returning lines into iqueue and arbitrates decode reads.
module ifetch_ctrl #(
  parameter int                ADDR_W  = 32,
  parameter int                LINE_W  = 128,
  parameter int                DEPTH   = 4,
  parameter int                MAX_OUT = 2,
  parameter logic [ADDR_W-1:0] BOOT_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              ic_req_o,
  output logic [ADDR_W-1:0] ic_addr_o,
  input  logic              ic_gnt_i,
  input  logic              ic_valid_i,
  input  logic [LINE_W-1:0] ic_data_i,
  output logic              iq_wr_o,
  output logic [LINE_W-1:0] iq_data_o,
  output logic              iq_rd_o,
  output logic              iq_flush_no,
  input  logic              rd_req_i,
  output logic              rd_ack_o,
  output logic              inst_avail_o
);

  localparam int LINE_BYTES = LINE_W / 8;
  localparam int CW         = $clog2(DEPTH + MAX_OUT + 1);

  localparam logic [CW-1:0]     DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0]     MAX_C      = CW'(MAX_OUT);
  localparam logic [ADDR_W-1:0] LINE_INC   = ADDR_W'(LINE_BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(LINE_BYTES - 1));

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [CW-1:0]     r_occ;
  logic [CW-1:0]     r_out;
  logic [CW-1:0]     r_drop;
  logic              r_pend;

  logic w_run;
  logic w_space;
  logic w_req;
  logic w_fire;
  logic w_wr;
  logic w_ack;

  assign w_run   = (r_state == S_RUN);
  // occ+out bounded by DEPTH means every granted line already owns a queue slot
  assign w_space = ((r_occ + r_out) < DEPTH_C) && (r_out < MAX_C);
  // r_pend keeps an ungranted request up even if en_i falls before the grant
  assign w_req   = w_run && !redirect_i && (r_pend || (en_i && w_space));
  assign w_fire  = w_req && ic_gnt_i;
  assign w_wr    = w_run && !redirect_i && ic_valid_i && (r_drop == '0);
  assign w_ack   = w_run && !redirect_i && rd_req_i && (r_occ != '0) && !w_wr;

  assign ic_req_o     = w_req;
  assign ic_addr_o    = r_pc;
  assign iq_wr_o      = w_wr;
  assign iq_data_o    = ic_data_i;
  assign iq_rd_o      = w_ack;
  assign rd_ack_o     = w_ack;
  assign iq_flush_no  = (r_state != S_FLUSH);
  assign inst_avail_o = (r_occ != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_pc    <= BOOT_PC;
      r_occ   <= '0;
      r_out   <= '0;
      r_drop  <= '0;
      r_pend  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:  if (en_i) r_state <= S_RUN;
        S_RUN:   if (redirect_i) r_state <= S_FLUSH;
        S_FLUSH: if (!redirect_i) r_state <= S_RUN;
        default: r_state <= S_IDLE;
      endcase

      if (redirect_i) r_pc <= redirect_pc_i & ALIGN_MASK;
      else if (w_fire) r_pc <= r_pc + LINE_INC;

      r_pend <= w_req && !ic_gnt_i;
      r_out  <= r_out + CW'(w_fire) - CW'(ic_valid_i);

      if (r_state == S_FLUSH) r_occ <= '0;
      else r_occ <= r_occ + CW'(w_wr) - CW'(w_ack);

      // Outside steady RUN every line still in flight is stale, so drop tracks out
      if (redirect_i || (r_state != S_RUN))
        r_drop <= r_out + CW'(w_fire) - CW'(ic_valid_i);
      else if (ic_valid_i && (r_drop != '0))
        r_drop <= r_drop - CW'(1'b1);
    end
  end

`ifndef SYNTHESIS
  a_space: assert property (@(posedge clk_i) disable iff (!rst_ni) ((r_occ + r_out) <= DEPTH_C));
  a_drop:  assert property (@(posedge clk_i) disable iff (!rst_ni) (r_drop <= r_out));
  a_full:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(w_wr && (r_occ == DEPTH_C)));
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed scenarios plus randomized traffic compared
// against a queue-based model of the fetch stream, the I-cache and the instruction queue.
module tb_ifetch_ctrl;
  localparam int          ADDR_W  = 32;
  localparam int          LINE_W  = 128;
  localparam int          DEPTH   = 4;
  localparam int          MAX_OUT = 2;
  localparam logic [31:0] BOOT_PC = 32'h0000_0000;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              en_i;
  logic              redirect_i;
  logic [ADDR_W-1:0] redirect_pc_i;
  logic              ic_req_o;
  logic [ADDR_W-1:0] ic_addr_o;
  logic              ic_gnt_i;
  logic              ic_valid_i;
  logic [LINE_W-1:0] ic_data_i;
  logic              iq_wr_o;
  logic [LINE_W-1:0] iq_data_o;
  logic              iq_rd_o;
  logic              iq_flush_no;
  logic              rd_req_i;
  logic              rd_ack_o;
  logic              inst_avail_o;

  always #5 clk_i = ~clk_i;

  ifetch_ctrl #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .BOOT_PC(BOOT_PC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o),
    .ic_gnt_i(ic_gnt_i), .ic_valid_i(ic_valid_i), .ic_data_i(ic_data_i),
    .iq_wr_o(iq_wr_o), .iq_data_o(iq_data_o), .iq_rd_o(iq_rd_o),
    .iq_flush_no(iq_flush_no), .rd_req_i(rd_req_i), .rd_ack_o(rd_ack_o),
    .inst_avail_o(inst_avail_o)
  );

  // Reference model: requests in flight tagged with the fetch epoch they belong to;
  // a redirect starts a new epoch, so older lines are stale and must never reach iqueue.
  typedef struct {
    logic [31:0] addr;
    int          ep;
  } req_t;

  req_t         cq[$];
  logic [127:0] iq_m[$];
  int           m_mode;  // 0 idle, 1 run, 2 flush
  logic [31:0]  m_pc;
  logic [31:0]  m_rd_pc;
  int           m_epoch = 0;
  bit           m_held;

  bit           exp_req, exp_wr, exp_ack, exp_flush_n, exp_avail;
  logic [31:0]  exp_addr;
  logic [127:0] exp_data;
  logic [127:0] last_rd, last_rd_exp;
  bit           last_rd_vld;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [127:0] line(input logic [31:0] a);
    return {a ^ 32'hA5A5_0000, ~a, a + 32'h1111_1111, a};
  endfunction

  task automatic model_reset();
    cq.delete();
    iq_m.delete();
    m_mode      = 0;
    m_pc        = BOOT_PC;
    m_rd_pc     = BOOT_PC;
    m_held      = 0;
    m_epoch++;
    last_rd_vld = 0;
  endtask

  task automatic model_eval();
    int occ;
    int outn;
    bit run;
    occ         = iq_m.size();
    outn        = cq.size();
    run         = (m_mode == 1);
    exp_addr    = m_pc;
    exp_flush_n = (m_mode != 2);
    exp_avail   = (occ != 0);
    exp_req     = run && !redirect_i &&
                  (m_held || (en_i && (occ + outn < DEPTH) && (outn < MAX_OUT)));
    exp_wr      = 0;
    exp_data    = '0;
    if (outn > 0) begin
      exp_wr   = run && !redirect_i && ic_valid_i && (cq[0].ep == m_epoch);
      exp_data = line(cq[0].addr);
    end
    exp_ack     = run && !redirect_i && rd_req_i && (occ != 0) && !exp_wr;
  endtask

  task automatic cache_drive(input int gnt_pct, input int vld_pct);
    ic_gnt_i   = ($urandom_range(99) < gnt_pct);
    ic_valid_i = (cq.size() > 0) && ($urandom_range(99) < vld_pct);
    ic_data_i  = ic_valid_i ? line(cq[0].addr) : {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // Advance one clock and move the model forward with the inputs that were applied.
  task automatic tick();
    logic [127:0] d;
    bit           fire;
    req_t         e;
    model_eval();
    d    = iq_data_o;
    fire = exp_req && ic_gnt_i;
    @(posedge clk_i);
    last_rd_vld = 0;
    if (ic_valid_i && cq.size() > 0) begin
      void'(cq.pop_front());
      if (exp_wr) iq_m.push_back(d);
    end
    if (fire) begin
      e.addr = m_pc;
      e.ep   = m_epoch;
      cq.push_back(e);
      m_pc   = m_pc + 32'd16;
    end
    m_held = exp_req && !ic_gnt_i;
    if (exp_ack) begin
      last_rd     = iq_m.pop_front();
      last_rd_exp = line(m_rd_pc);
      last_rd_vld = 1;
      m_rd_pc     = m_rd_pc + 32'd16;
    end
    if (m_mode == 2) iq_m.delete();
    case (m_mode)
      0:       if (en_i) m_mode = 1;
      1:       if (redirect_i) m_mode = 2;
      default: if (!redirect_i) m_mode = 1;
    endcase
    if (redirect_i) begin
      m_pc    = redirect_pc_i & ~32'hF;
      m_rd_pc = m_pc;
      m_epoch++;
      m_held  = 0;
    end
    @(negedge clk_i);
  endtask

  // Let every in-flight line come home and the queue empty out, without fetching more.
  task automatic drain_all();
    en_i       = 0;
    redirect_i = 0;
    rd_req_i   = 1;
    for (int k = 0; k < 60 && (cq.size() != 0 || iq_m.size() != 0 || m_held); k++) begin
      cache_drive(100, 100);
      #1;
      tick();
    end
    rd_req_i = 0;
  endtask

  task automatic test_reset();
    rst_ni = 0; en_i = 0; redirect_i = 0; redirect_pc_i = '0;
    ic_gnt_i = 0; ic_valid_i = 0; ic_data_i = '0; rd_req_i = 0;
    repeat (2) @(negedge clk_i);
    model_reset();
    #1;
    n_chk++; if (ic_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b want=0", ic_req_o); end
    n_chk++; if (ic_addr_o !== BOOT_PC) begin n_fail++; $display("FAIL reset_addr got=%h want=%h", ic_addr_o, BOOT_PC); end
    n_chk++; if (iq_wr_o !== 1'b0) begin n_fail++; $display("FAIL reset_wr got=%b want=0", iq_wr_o); end
    n_chk++; if (iq_rd_o !== 1'b0) begin n_fail++; $display("FAIL reset_rd got=%b want=0", iq_rd_o); end
    n_chk++; if (rd_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b want=0", rd_ack_o); end
    n_chk++; if (iq_flush_no !== 1'b1) begin n_fail++; $display("FAIL reset_flush got=%b want=1", iq_flush_no); end
    n_chk++; if (inst_avail_o !== 1'b0) begin n_fail++; $display("FAIL reset_avail got=%b want=0", inst_avail_o); end
    @(negedge clk_i);
    rst_ni = 1;
  endtask

  task automatic test_fill();
    logic [31:0] got[$];
    logic [31:0] a;
    int          wrs = 0;
    en_i = 1; rd_req_i = 0; redirect_i = 0;
    for (int c = 0; c < 10; c++) begin
      cache_drive(100, 100);
      #1;
      model_eval();
      n_chk++; if (ic_req_o !== exp_req) begin n_fail++; $display("FAIL fill_req cyc=%0d got=%b want=%b", c, ic_req_o, exp_req); end
      if (ic_req_o && ic_gnt_i) got.push_back(ic_addr_o);
      if (iq_wr_o) wrs++;
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      a = (i < got.size()) ? got[i] : 32'hFFFF_FFFF;
      n_chk++; if (a !== 32'(i * 16)) begin n_fail++; $display("FAIL fill_addr%0d got=%h want=%h", i, a, 32'(i * 16)); end
    end
    n_chk++; if (got.size() != 4) begin n_fail++; $display("FAIL fill_nreq got=%0d want=4", got.size()); end
    n_chk++; if (wrs != 4) begin n_fail++; $display("FAIL fill_nwr got=%0d want=4", wrs); end
    ic_gnt_i = 0; ic_valid_i = 0;
    #1;
    n_chk++; if (ic_req_o !== 1'b0) begin n_fail++; $display("FAIL fill_full_req got=%b want=0", ic_req_o); end
    n_chk++; if (inst_avail_o !== 1'b1) begin n_fail++; $display("FAIL fill_avail got=%b want=1", inst_avail_o); end
  endtask

  task automatic test_drain();
    logic [31:0] new_addr = 32'hFFFF_FFFF;
    bit          seen = 0;
    int          acks = 0;
    en_i = 1; rd_req_i = 1;
    for (int c = 0; c < 12; c++) begin
      cache_drive(100, 100);
      #1;
      model_eval();
      n_chk++; if (rd_ack_o !== exp_ack) begin n_fail++; $display("FAIL drain_ack cyc=%0d got=%b want=%b", c, rd_ack_o, exp_ack); end
      n_chk++; if (iq_wr_o !== exp_wr) begin n_fail++; $display("FAIL drain_wr cyc=%0d got=%b want=%b", c, iq_wr_o, exp_wr); end
      if (!seen && ic_req_o && ic_gnt_i) begin new_addr = ic_addr_o; seen = 1; end
      tick();
      if (last_rd_vld) begin
        acks++;
        n_chk++; if (last_rd !== last_rd_exp) begin n_fail++; $display("FAIL drain_order got=%h want=%h", last_rd, last_rd_exp); end
      end
    end
    n_chk++; if (acks < 4) begin n_fail++; $display("FAIL drain_acks got=%0d want>=4", acks); end
    n_chk++; if (new_addr !== 32'h40) begin n_fail++; $display("FAIL drain_refetch got=%h want=00000040", new_addr); end
    en_i = 0;
    for (int c = 0; c < 20 && inst_avail_o; c++) begin
      cache_drive(100, 100);
      #1;
      tick();
      if (last_rd_vld) begin
        n_chk++; if (last_rd !== last_rd_exp) begin n_fail++; $display("FAIL drain_order2 got=%h want=%h", last_rd, last_rd_exp); end
      end
    end
    ic_valid_i = 0; ic_gnt_i = 0;
    #1;
    if (cq.size() == 0) begin
      n_chk++; if (inst_avail_o !== 1'b0) begin n_fail++; $display("FAIL drain_avail got=%b want=0", inst_avail_o); end
      n_chk++; if (rd_ack_o !== 1'b0) begin n_fail++; $display("FAIL drain_empty_ack got=%b want=0", rd_ack_o); end
    end
  endtask

  task automatic test_collide();
    drain_all();
    en_i = 1; rd_req_i = 0;
    for (int k = 0; k < 10 && cq.size() < 2; k++) begin
      ic_gnt_i = 1; ic_valid_i = 0;
      #1;
      tick();
    end
    en_i = 0;
    cache_drive(0, 100);
    #1;
    n_chk++; if (iq_wr_o !== 1'b1) begin n_fail++; $display("FAIL coll_first_wr got=%b want=1", iq_wr_o); end
    tick();
    rd_req_i = 1;
    cache_drive(0, 100);
    #1;
    n_chk++; if (iq_wr_o !== 1'b1) begin n_fail++; $display("FAIL coll_wr got=%b want=1", iq_wr_o); end
    n_chk++; if (rd_ack_o !== 1'b0) begin n_fail++; $display("FAIL coll_ack got=%b want=0", rd_ack_o); end
    n_chk++; if (iq_rd_o !== 1'b0) begin n_fail++; $display("FAIL coll_rd got=%b want=0", iq_rd_o); end
    tick();
    cache_drive(0, 0);
    #1;
    n_chk++; if (rd_ack_o !== 1'b1) begin n_fail++; $display("FAIL coll_ack_next got=%b want=1", rd_ack_o); end
    tick();
    drain_all();
  endtask

  task automatic test_redirect();
    drain_all();
    en_i = 1; rd_req_i = 0;
    for (int k = 0; k < 10 && cq.size() < 2; k++) begin
      ic_gnt_i = 1; ic_valid_i = 0;
      #1;
      tick();
    end
    redirect_i = 1; redirect_pc_i = 32'h1234; ic_gnt_i = 1; ic_valid_i = 0;
    #1;
    n_chk++; if (ic_req_o !== 1'b0) begin n_fail++; $display("FAIL redir_req got=%b want=0", ic_req_o); end
    tick();
    redirect_i = 0;
    cache_drive(0, 100);
    #1;
    n_chk++; if (iq_flush_no !== 1'b0) begin n_fail++; $display("FAIL redir_flush got=%b want=0", iq_flush_no); end
    n_chk++; if (iq_wr_o !== 1'b0) begin n_fail++; $display("FAIL redir_drop1 got=%b want=0", iq_wr_o); end
    n_chk++; if (ic_req_o !== 1'b0) begin n_fail++; $display("FAIL redir_flush_req got=%b want=0", ic_req_o); end
    tick();
    cache_drive(0, 100);
    #1;
    n_chk++; if (iq_flush_no !== 1'b1) begin n_fail++; $display("FAIL redir_flush_end got=%b want=1", iq_flush_no); end
    n_chk++; if (iq_wr_o !== 1'b0) begin n_fail++; $display("FAIL redir_drop2 got=%b want=0", iq_wr_o); end
    n_chk++; if (ic_req_o !== 1'b1) begin n_fail++; $display("FAIL redir_resume got=%b want=1", ic_req_o); end
    n_chk++; if (ic_addr_o !== 32'h1230) begin n_fail++; $display("FAIL redir_addr got=%h want=00001230", ic_addr_o); end
    n_chk++; if (inst_avail_o !== 1'b0) begin n_fail++; $display("FAIL redir_occ got=%b want=0", inst_avail_o); end
    tick();
    ic_gnt_i = 1; ic_valid_i = 0;
    #1;
    tick();
    cache_drive(0, 100);
    #1;
    n_chk++; if (iq_wr_o !== 1'b1) begin n_fail++; $display("FAIL redir_new_wr got=%b want=1", iq_wr_o); end
    n_chk++; if (iq_data_o !== line(32'h1230)) begin n_fail++; $display("FAIL redir_new_data got=%h want=%h", iq_data_o, line(32'h1230)); end
    tick();
  endtask

  task automatic test_redirect_gnt();
    drain_all();
    en_i = 1; rd_req_i = 0;
    for (int k = 0; k < 10 && cq.size() < 1; k++) begin
      ic_gnt_i = 1; ic_valid_i = 0;
      #1;
      tick();
    end
    redirect_i = 1; redirect_pc_i = 32'h2000; ic_gnt_i = 1; ic_valid_i = 0;
    #1;
    n_chk++; if (ic_req_o !== 1'b0) begin n_fail++; $display("FAIL rgnt_req got=%b want=0", ic_req_o); end
    tick();
    redirect_i = 0;
    cache_drive(0, 100);
    #1;
    n_chk++; if (iq_wr_o !== 1'b0) begin n_fail++; $display("FAIL rgnt_stale_wr got=%b want=0", iq_wr_o); end
    tick();
    ic_gnt_i = 1; ic_valid_i = 0;
    #1;
    n_chk++; if (ic_req_o !== 1'b1) begin n_fail++; $display("FAIL rgnt_resume got=%b want=1", ic_req_o); end
    n_chk++; if (ic_addr_o !== 32'h2000) begin n_fail++; $display("FAIL rgnt_addr got=%h want=00002000", ic_addr_o); end
    tick();
    en_i = 0;
    cache_drive(0, 100);
    #1;
    n_chk++; if (iq_wr_o !== 1'b1) begin n_fail++; $display("FAIL rgnt_new_wr got=%b want=1", iq_wr_o); end
    tick();
    drain_all();
  endtask

  task automatic test_async_reset();
    en_i = 1; rd_req_i = 0;
    for (int c = 0; c < 4; c++) begin
      cache_drive(100, 60);
      #1;
      tick();
    end
    cache_drive(100, 100);
    rd_req_i = 1;
    #2;
    rst_ni = 0;
    #1;
    n_chk++; if (ic_req_o !== 1'b0) begin n_fail++; $display("FAIL arst_req got=%b want=0", ic_req_o); end
    n_chk++; if (ic_addr_o !== BOOT_PC) begin n_fail++; $display("FAIL arst_addr got=%h want=%h", ic_addr_o, BOOT_PC); end
    n_chk++; if (iq_wr_o !== 1'b0) begin n_fail++; $display("FAIL arst_wr got=%b want=0", iq_wr_o); end
    n_chk++; if (rd_ack_o !== 1'b0) begin n_fail++; $display("FAIL arst_ack got=%b want=0", rd_ack_o); end
    n_chk++; if (iq_flush_no !== 1'b1) begin n_fail++; $display("FAIL arst_flush got=%b want=1", iq_flush_no); end
    n_chk++; if (inst_avail_o !== 1'b0) begin n_fail++; $display("FAIL arst_avail got=%b want=0", inst_avail_o); end
    model_reset();
    @(negedge clk_i);
    ic_gnt_i = 0; ic_valid_i = 0; rd_req_i = 0; en_i = 0;
    @(negedge clk_i);
    rst_ni = 1; en_i = 1;
    #1;
    n_chk++; if (ic_req_o !== 1'b0) begin n_fail++; $display("FAIL arst_idle_req got=%b want=0", ic_req_o); end
    tick();
    #1;
    n_chk++; if (ic_req_o !== 1'b1) begin n_fail++; $display("FAIL arst_restart_req got=%b want=1", ic_req_o); end
    n_chk++; if (ic_addr_o !== BOOT_PC) begin n_fail++; $display("FAIL arst_restart_addr got=%h want=%h", ic_addr_o, BOOT_PC); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 2500; c++) begin
      en_i          = ($urandom_range(7) != 0);
      redirect_i    = ($urandom_range(31) == 0);
      redirect_pc_i = $urandom();
      rd_req_i      = $urandom_range(1);
      cache_drive(60, 50);
      #1;
      model_eval();
      n_chk++; if (ic_req_o !== exp_req) begin n_fail++; $display("FAIL rnd_req cyc=%0d got=%b want=%b", c, ic_req_o, exp_req); end
      n_chk++; if (ic_addr_o !== exp_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", c, ic_addr_o, exp_addr); end
      n_chk++; if (iq_wr_o !== exp_wr) begin n_fail++; $display("FAIL rnd_wr cyc=%0d got=%b want=%b", c, iq_wr_o, exp_wr); end
      n_chk++; if (iq_rd_o !== exp_ack) begin n_fail++; $display("FAIL rnd_rd cyc=%0d got=%b want=%b", c, iq_rd_o, exp_ack); end
      n_chk++; if (rd_ack_o !== exp_ack) begin n_fail++; $display("FAIL rnd_ack cyc=%0d got=%b want=%b", c, rd_ack_o, exp_ack); end
      n_chk++; if (iq_flush_no !== exp_flush_n) begin n_fail++; $display("FAIL rnd_flush cyc=%0d got=%b want=%b", c, iq_flush_no, exp_flush_n); end
      n_chk++; if (inst_avail_o !== exp_avail) begin n_fail++; $display("FAIL rnd_avail cyc=%0d got=%b want=%b", c, inst_avail_o, exp_avail); end
      if (exp_wr) begin
        n_chk++; if (iq_data_o !== exp_data) begin n_fail++; $display("FAIL rnd_data cyc=%0d got=%h want=%h", c, iq_data_o, exp_data); end
      end
      tick();
      if (last_rd_vld) begin
        n_chk++; if (last_rd !== last_rd_exp) begin n_fail++; $display("FAIL rnd_order cyc=%0d got=%h want=%h", c, last_rd, last_rd_exp); end
      end
    end
    redirect_i = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_collide();
    test_redirect();
    test_redirect_gnt();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
